// File: rtl/sort4_ctrl_pkg.sv
// ------------------------------------------------------------------
// sort4_ctrl_pkg : shared constants and state encoding for sort4_ctrl
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package sort4_ctrl_pkg;

  localparam int ELEM_CNT   = 4;
  localparam int SWAP_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sort4_ctrl_if.sv
// ------------------------------------------------------------------
// sort4_ctrl_if : operand/result handshake bundle of the 4-element sorter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface sort4_ctrl_if
  import sort4_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic                      in_valid;
  logic                      in_ready;
  logic [ELEM_CNT*WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [ELEM_CNT*WIDTH-1:0] out_data;
  logic [SWAP_CNT_W-1:0]     swap_cnt;
  logic                      busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, swap_cnt, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, swap_cnt, busy
  );

endinterface

`default_nettype wire

// File: rtl/sort4_ctrl_comparator_nb.sv
// ------------------------------------------------------------------
// comparator_nb : combinational unsigned magnitude comparator
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module comparator_nb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             gt_o,
  output logic             eq_o,
  output logic             lt_o
);

  assign gt_o = (a_i >  b_i);
  assign eq_o = (a_i == b_i);
  assign lt_o = (a_i <  b_i);

endmodule

`default_nettype wire

// File: rtl/sort4_ctrl.sv
// ------------------------------------------------------------------
// sort4_ctrl : 4-element bubble sorter, one shared compare per cycle
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sort4_ctrl
  import sort4_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter bit DESCEND = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  sort4_ctrl_if.slave  bus
);

  typedef logic [ELEM_CNT-1:0][WIDTH-1:0] vec_t;

  state_t                state_q, state_d;
  vec_t                  elem_q, elem_d;
  vec_t                  out_data_q, out_data_d;
  logic [1:0]            pass_q, pass_d;
  logic [1:0]            pair_q, pair_d;
  logic                  swapped_q, swapped_d;
  logic [SWAP_CNT_W-1:0] swap_cnt_q, swap_cnt_d;
  logic                  busy_q;
  logic                  out_valid_q;

  logic [1:0]            w_pair_nxt;
  logic [WIDTH-1:0]      w_op_a, w_op_b;
  logic                  w_gt, w_eq, w_lt;
  logic                  w_swap, w_last_pair, w_any_swap;

  assign w_pair_nxt = pair_q + 2'd1;
  assign w_op_a     = elem_q[pair_q];
  assign w_op_b     = elem_q[w_pair_nxt];

  comparator_nb #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a_i  (w_op_a),
    .b_i  (w_op_b),
    .gt_o (w_gt),
    .eq_o (w_eq),
    .lt_o (w_lt)
  );

  // Equal operands are never exchanged, which keeps the sort stable.
  assign w_swap      = !w_eq && (DESCEND ? w_lt : w_gt);
  assign w_last_pair = (pair_q == (2'd2 - pass_q));
  assign w_any_swap  = swapped_q | w_swap;

  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    out_data_d = out_data_q;
    pass_d     = pass_q;
    pair_d     = pair_q;
    swapped_d  = swapped_q;
    swap_cnt_d = swap_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d    = ST_CMP;
          elem_d     = bus.in_data;
          pass_d     = 2'd0;
          pair_d     = 2'd0;
          swapped_d  = 1'b0;
          swap_cnt_d = '0;
        end
      end
      ST_CMP: begin
        if (w_swap) begin
          elem_d[pair_q]     = w_op_b;
          elem_d[w_pair_nxt] = w_op_a;
          swap_cnt_d         = swap_cnt_q + 1'b1;
        end
        if (w_last_pair) begin
          // A clean pass means sorted; pass 2 is always the final one.
          if (!w_any_swap || (pass_q == 2'd2)) begin
            state_d    = ST_DONE;
            out_data_d = elem_d;
          end else begin
            pass_d    = pass_q + 2'd1;
            pair_d    = 2'd0;
            swapped_d = 1'b0;
          end
        end else begin
          pair_d    = w_pair_nxt;
          swapped_d = w_any_swap;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      elem_q      <= '0;
      out_data_q  <= '0;
      pass_q      <= 2'd0;
      pair_q      <= 2'd0;
      swapped_q   <= 1'b0;
      swap_cnt_q  <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      out_data_q  <= out_data_d;
      pass_q      <= pass_d;
      pair_q      <= pair_d;
      swapped_q   <= swapped_d;
      swap_cnt_q  <= swap_cnt_d;
      busy_q      <= (state_d == ST_CMP);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.swap_cnt  = swap_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sort4_ctrl.sv
// ------------------------------------------------------------------
// tb_sort4_ctrl : self-checking bench for ascending and descending sorters
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_sort4_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  sort4_ctrl_if #(.WIDTH(4)) ifa ();
  sort4_ctrl_if #(.WIDTH(4)) ifd ();

  sort4_ctrl #(.WIDTH(4), .DESCEND(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  sort4_ctrl #(.WIDTH(4), .DESCEND(1'b1)) dut_d (.clk(clk), .rst_n(rst_n), .bus(ifd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: stable sort by rank, swaps = inversions, passes from max left-displacement.
  function automatic void model(input logic [15:0] v, input bit desc,
                                output logic [15:0] s, output int cnt, output int k);
    int e[4];
    int m, l, r, p;
    for (int i = 0; i < 4; i++) e[i] = int'(v[i*4 +: 4]);
    s = '0; cnt = 0; m = 0;
    for (int j = 0; j < 4; j++) begin
      l = 0; r = 0;
      for (int i = 0; i < 4; i++) begin
        if (desc ? (e[i] > e[j]) : (e[i] < e[j])) r++;
        else if ((e[i] == e[j]) && (i < j)) r++;
        if ((i < j) && (desc ? (e[i] < e[j]) : (e[i] > e[j]))) l++;
      end
      s[r*4 +: 4] = v[j*4 +: 4];
      cnt += l;
      if (l > m) m = l;
    end
    p = (m + 1 < 3) ? m + 1 : 3;
    k = (p == 1) ? 3 : ((p == 2) ? 5 : 6);
  endfunction

  task automatic send(input bit desc, input logic [15:0] vec,
                      output logic [15:0] dout, output int cnt, output int lat, output int bcnt);
    int  n;
    bit  ov, bz;
    if (desc) begin ifd.in_valid = 1'b1; ifd.in_data = vec; end
    else      begin ifa.in_valid = 1'b1; ifa.in_data = vec; end
    @(posedge clk); #1;
    if (desc) begin ifd.in_valid = 1'b0; ifd.in_data = 16'($urandom); end
    else      begin ifa.in_valid = 1'b0; ifa.in_data = 16'($urandom); end
    bcnt = 0;
    for (n = 0; n < 20; n++) begin
      ov = desc ? ifd.out_valid : ifa.out_valid;
      bz = desc ? ifd.busy : ifa.busy;
      if (ov) break;
      if (bz) bcnt++;
      @(posedge clk); #1;
    end
    lat  = n + 1;
    dout = desc ? ifd.out_data : ifa.out_data;
    cnt  = desc ? int'(ifd.swap_cnt) : int'(ifa.swap_cnt);
  endtask

  task automatic take(input bit desc);
    if (desc) ifd.out_ready = 1'b1; else ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    if (desc) ifd.out_ready = 1'b0; else ifa.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ifa.in_ready, ifa.out_valid, ifa.busy, ifa.out_data, ifa.swap_cnt} !== {1'b1, 1'b0, 1'b0, 16'h0, 3'd0})
      $display("FAIL reset_a rdy/ov/busy/data/cnt got %b/%b/%b/%h/%0d want 1/0/0/0000/0",
               ifa.in_ready, ifa.out_valid, ifa.busy, ifa.out_data, ifa.swap_cnt);
    else passed++;
    checks++;
    if ({ifd.in_ready, ifd.out_valid, ifd.busy, ifd.out_data, ifd.swap_cnt} !== {1'b1, 1'b0, 1'b0, 16'h0, 3'd0})
      $display("FAIL reset_d rdy/ov/busy/data/cnt got %b/%b/%b/%h/%0d want 1/0/0/0000/0",
               ifd.in_ready, ifd.out_valid, ifd.busy, ifd.out_data, ifd.swap_cnt);
    else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] vin[6], vexp[6], d;
    int          cexp[6], lexp[6];
    bit          dsc[6];
    int          c, l, b;
    vin[0] = {4'd1, 4'd7, 4'd5, 4'd9};   vexp[0] = {4'd9, 4'd7, 4'd5, 4'd1};   cexp[0] = 5; lexp[0] = 7; dsc[0] = 0;
    vin[1] = {4'd0, 4'd5, 4'd10, 4'd15}; vexp[1] = {4'd15, 4'd10, 4'd5, 4'd0}; cexp[1] = 6; lexp[1] = 7; dsc[1] = 0;
    vin[2] = {4'd0, 4'd5, 4'd10, 4'd15}; vexp[2] = {4'd0, 4'd5, 4'd10, 4'd15}; cexp[2] = 0; lexp[2] = 4; dsc[2] = 1;
    vin[3] = {4'd4, 4'd3, 4'd2, 4'd1};   vexp[3] = {4'd4, 4'd3, 4'd2, 4'd1};   cexp[3] = 0; lexp[3] = 4; dsc[3] = 0;
    vin[4] = {4'd7, 4'd7, 4'd7, 4'd7};   vexp[4] = {4'd7, 4'd7, 4'd7, 4'd7};   cexp[4] = 0; lexp[4] = 4; dsc[4] = 0;
    vin[5] = {4'd1, 4'd2, 4'd2, 4'd3};   vexp[5] = {4'd3, 4'd2, 4'd2, 4'd1};   cexp[5] = 5; lexp[5] = 7; dsc[5] = 0;
    for (int t = 0; t < 6; t++) begin
      send(dsc[t], vin[t], d, c, l, b);
      checks++;
      if (d !== vexp[t]) $display("FAIL directed%0d data got %h want %h", t, d, vexp[t]);
      else passed++;
      checks++;
      if (c != cexp[t]) $display("FAIL directed%0d swap_cnt got %0d want %0d", t, c, cexp[t]);
      else passed++;
      checks++;
      if ((l != lexp[t]) || (b != lexp[t] - 1))
        $display("FAIL directed%0d latency/busy got %0d/%0d want %0d/%0d", t, l, b, lexp[t], lexp[t] - 1);
      else passed++;
      take(dsc[t]);
    end
  endtask

  task automatic test_random();
    logic [15:0] v, d, s;
    int          c, l, b, ce, ke;
    bit          desc;
    for (int t = 0; t < 60; t++) begin
      desc = t[0];
      for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(0, (t % 4 < 2) ? 3 : 15));
      model(v, desc, s, ce, ke);
      send(desc, v, d, c, l, b);
      checks++;
      if ((d !== s) || (c != ce) || (l != ke + 1) || (b != ke))
        $display("FAIL random%0d in %h desc %0d got data/cnt/lat/busy %h/%0d/%0d/%0d want %h/%0d/%0d/%0d",
                 t, v, desc, d, c, l, b, s, ce, ke + 1, ke);
      else passed++;
      take(desc);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d, s;
    int          c, l, b, ce, ke;
    model({4'd2, 4'd9, 4'd4, 4'd6}, 1'b0, s, ce, ke);
    send(1'b0, {4'd2, 4'd9, 4'd4, 4'd6}, d, c, l, b);
    for (int i = 0; i < 5; i++) begin
      ifa.in_valid = 1'b1;
      ifa.in_data  = 16'h5a3c;
      @(posedge clk); #1;
      checks++;
      if ((ifa.out_data !== s) || (int'(ifa.swap_cnt) != ce) || (ifa.in_ready !== 1'b0) || (ifa.out_valid !== 1'b1))
        $display("FAIL backpressure%0d data/cnt/rdy/ov got %h/%0d/%b/%b want %h/%0d/0/1",
                 i, ifa.out_data, ifa.swap_cnt, ifa.in_ready, ifa.out_valid, s, ce);
      else passed++;
    end
    ifa.in_valid = 1'b0;
    take(1'b0);
    checks++;
    if ((ifa.in_ready !== 1'b1) || (ifa.out_valid !== 1'b0) || (ifa.busy !== 1'b0))
      $display("FAIL release rdy/ov/busy got %b/%b/%b want 1/0/0", ifa.in_ready, ifa.out_valid, ifa.busy);
    else passed++;
  endtask

  task automatic test_reset_mid_cmp();
    logic [15:0] d;
    int          c, l, b;
    ifa.in_valid = 1'b1;
    ifa.in_data  = {4'd1, 4'd7, 4'd5, 4'd9};
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (ifa.busy !== 1'b1) $display("FAIL midcmp_busy got %b want 1", ifa.busy);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ifa.in_ready, ifa.out_valid, ifa.busy, ifa.out_data, ifa.swap_cnt} !== {1'b1, 1'b0, 1'b0, 16'h0, 3'd0})
      $display("FAIL midcmp_reset rdy/ov/busy/data/cnt got %b/%b/%b/%h/%0d want 1/0/0/0000/0",
               ifa.in_ready, ifa.out_valid, ifa.busy, ifa.out_data, ifa.swap_cnt);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      checks++;
      if (ifa.out_valid !== 1'b0) $display("FAIL aborted_out_valid got %b want 0", ifa.out_valid);
      else passed++;
    end
    send(1'b0, {4'd0, 4'd5, 4'd10, 4'd15}, d, c, l, b);
    checks++;
    if ((d !== {4'd15, 4'd10, 4'd5, 4'd0}) || (c != 6) || (l != 7))
      $display("FAIL after_reset data/cnt/lat got %h/%0d/%0d want fa50/6/7", d, c, l);
    else passed++;
    take(1'b0);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b0;
    ifd.in_valid = 1'b0; ifd.in_data = '0; ifd.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_cmp();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
